// File: rtl/inst_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// inst_fetch_ctrl
//
// Instruction-fetch sequencer for the RV32 core. Owns the program counter,
// issues one outstanding word request at a time to instruction memory,
// buffers the returned word together with its PC for decode, and handles
// redirects from execute by discarding any stale in-flight fetch.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : a redirect whose target has bits [1:0] != 0 traps into a
//               terminal FAULT state and raises fetch_misaligned (sticky
//               until rst_n).
//   undefined : the low two target bits are dropped when a redirect is
//               latched; fetch_misaligned is tied to 0.
//
// Ports
//   clk, rst_n        core clock / asynchronous active-low reset
//   imem_req_valid    fetch request valid (held with its address until ready)
//   imem_req_ready    memory accepts the request this cycle
//   imem_req_addr     word address of the request (bits [1:0] always 0)
//   imem_rsp_valid    response valid, one per accepted request
//   imem_rsp_data     returned instruction word
//   id_valid          id_inst/id_pc hold a fetched instruction
//   id_ready          decode accepts the instruction
//   id_inst, id_pc    instruction and its address
//   redirect_valid    one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc       new fetch address
//   fetch_misaligned  sticky misaligned-redirect fault
//   fsm_state         current sequencer state, for debug/observation
//
// Handshakes: a transfer on either the imem request channel or the id
// channel happens on a rising edge where valid and ready are both high.
// Once valid is raised it, and the payload, stay unchanged until that
// transfer happens (the only exceptions are a redirect while id_valid is
// high, which withdraws the stale instruction, and entry to FAULT).
// ----------------------------------------------------------------------------
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misaligned,
    output logic [2:0]  fsm_state
);

    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
`ifdef MISALIGN_TRAP_EN
    localparam logic [2:0] S_FAULT = 3'd5;
`endif

    logic [2:0]  state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        pend;
    logic [31:0] id_inst_q;
    logic [31:0] id_pc_q;
    logic [31:0] redir_tgt;

`ifdef MISALIGN_TRAP_EN
    logic fault_q;
    logic redir_bad;

    assign redir_tgt        = redirect_pc;
    assign redir_bad        = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fetch_misaligned = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (state != S_FAULT && redir_bad) begin
            fault_q <= 1'b1;
        end
    end
`else
    // Word-align the target: the low two bits are simply discarded.
    assign redir_tgt        = redirect_pc & 32'hFFFF_FFFC;
    assign fetch_misaligned = 1'b0;
`endif

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = (state == S_REQ) ? pc : 32'h0000_0000;
    assign id_valid       = (state == S_HOLD);
    assign id_inst        = id_inst_q;
    assign id_pc          = id_pc_q;
    assign fsm_state      = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_BOOT;
            pc        <= RESET_PC;
            pend_pc   <= 32'h0000_0000;
            pend      <= 1'b0;
            id_inst_q <= 32'h0000_0000;
            id_pc_q   <= 32'h0000_0000;
        end else begin
`ifdef MISALIGN_TRAP_EN
            if (state == S_FAULT) begin
                // Terminal until reset; every input is ignored.
                state <= S_FAULT;
            end else if (redir_bad) begin
                state <= S_FAULT;
                pend  <= 1'b0;
            end else
`endif
            begin
                case (state)
                    S_BOOT: begin
                        if (redirect_valid) begin
                            pc <= redir_tgt;
                        end
                        state <= S_REQ;
                    end

                    S_REQ: begin
                        // The request on the bus is never altered; a redirect
                        // here is parked in pend_pc and applied once the
                        // stale response has been drained.
                        if (redirect_valid) begin
                            pend_pc <= redir_tgt;
                            pend    <= 1'b1;
                        end
                        if (imem_req_ready) begin
                            state <= (pend || redirect_valid) ? S_DRAIN : S_WAIT;
                        end
                    end

                    S_WAIT: begin
                        if (redirect_valid) begin
                            pc      <= redir_tgt;
                            pend_pc <= redir_tgt;
                            if (imem_rsp_valid) begin
                                // Stale response already here: drop it.
                                state <= S_REQ;
                            end else begin
                                pend  <= 1'b1;
                                state <= S_DRAIN;
                            end
                        end else if (imem_rsp_valid) begin
                            id_inst_q <= imem_rsp_data;
                            id_pc_q   <= pc;
                            pc        <= pc + 32'd4;
                            state     <= S_HOLD;
                        end
                    end

                    S_DRAIN: begin
                        if (redirect_valid) begin
                            pend_pc <= redir_tgt;
                        end
                        if (imem_rsp_valid) begin
                            // A redirect landing on the drain cycle is the newest.
                            pc    <= redirect_valid ? redir_tgt : pend_pc;
                            pend  <= 1'b0;
                            state <= S_REQ;
                        end
                    end

                    S_HOLD: begin
                        // With id_ready and redirect together, decode has
                        // taken the instruction and fetch restarts anyway.
                        if (redirect_valid) begin
                            pc    <= redir_tgt;
                            state <= S_REQ;
                        end else if (id_ready) begin
                            state <= S_REQ;
                        end
                    end

                    default: begin
                        state <= S_BOOT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//
// Bench for inst_fetch_ctrl. A memory process answers each accepted request
// after a programmable latency with a word derived from its address. A model
// process tracks, at the level of the architectural instruction stream, which
// PCs decode must receive in order and which fetch address a fresh request
// must carry; it checks the DUT on every cycle. Directed sections pin the
// cycle timing with hand-computed literals.
// ----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_misaligned;
  logic [2:0]  fsm_state;

  int n_vec = 0;
  int n_err = 0;

  inst_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .id_inst          (id_inst),
    .id_pc            (id_pc),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .fetch_misaligned (fetch_misaligned),
    .fsm_state        (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic to_drive;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_id(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (id_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: id_valid not seen within 60 cycles", nm);
    end
  endtask

  task automatic wait_accept(input string nm, output logic [31:0] a);
    bit ok;
    ok = 1'b0;
    a  = 32'hxxxx_xxxx;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        ok = 1'b1;
        a  = imem_req_addr;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: no accepted request within 60 cycles", nm);
    end
  endtask

  // ---------------- memory ----------------
  int          lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  initial begin
    logic        acc;
    logic        fired;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      acc   = imem_req_valid && imem_req_ready && rst_n;
      fired = imem_rsp_valid;
      a     = imem_req_addr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_cnt        = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end else begin
        if (fired) imem_rsp_valid = 1'b0;
        if (acc) begin
          mem_addr = a;
          mem_cnt  = lat;
        end
        if (mem_cnt > 0) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr);
          end
        end
      end
    end
  end

  // ---------------- stream model + per-cycle compare ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch = RST_PC;
  int          inflight = 0;
  bit          req_stale = 1'b0;
  bit          p_req_stall = 1'b0;
  logic [31:0] p_addr = 32'h0;
  bit          p_id_hold = 1'b0;
  logic [31:0] p_pc = 32'h0;
  logic [31:0] p_inst = 32'h0;
  bit          faulted = 1'b0;

  initial begin
    logic [31:0] e;
    logic [31:0] tgt;
    bit          stale;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_fetch   = RST_PC;
        inflight    = 0;
        req_stale   = 1'b0;
        p_req_stall = 1'b0;
        p_id_hold   = 1'b0;
        faulted     = 1'b0;
      end
`ifdef MISALIGN_TRAP_EN
      else if (faulted) begin
        chk("m_fault_flag", {31'b0, fetch_misaligned}, 32'd1);
        chk("m_fault_noreq", {31'b0, imem_req_valid}, 32'd0);
        chk("m_fault_noid", {31'b0, id_valid}, 32'd0);
      end
`endif
      else begin
        chk("m_misaligned_low", {31'b0, fetch_misaligned}, 32'd0);
        if (p_req_stall) begin
          chk("m_req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
          chk("m_req_hold_addr", imem_req_addr, p_addr);
        end
        if (p_id_hold) begin
          chk("m_id_hold_valid", {31'b0, id_valid}, 32'd1);
          chk("m_id_hold_pc", id_pc, p_pc);
          chk("m_id_hold_inst", id_inst, p_inst);
        end
        if (imem_req_valid) begin
          chk("m_req_align", {30'b0, imem_req_addr[1:0]}, 32'd0);
          chk("m_single_outstanding", inflight, 32'd0);
        end
        // decode transfer
        if (id_valid && id_ready) begin
          if (exp_q.size() == 0) begin
            chk("m_id_unexpected_pc", id_pc, 32'hxxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            chk("m_id_pc", id_pc, e);
            chk("m_id_inst", id_inst, mem_word(e));
          end
        end
        // memory response
        if (imem_rsp_valid && inflight > 0) inflight--;
        // request acceptance
        if (imem_req_valid && imem_req_ready) begin
          stale = req_stale || redirect_valid;
          if (!stale) begin
            chk("m_req_addr", imem_req_addr, exp_fetch);
            exp_q.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
          end
          inflight++;
          req_stale = 1'b0;
        end
        p_req_stall = imem_req_valid && !imem_req_ready;
        p_addr      = imem_req_addr;
        p_id_hold   = id_valid && !id_ready && !redirect_valid;
        p_pc        = id_pc;
        p_inst      = id_inst;
        // redirect restarts the architectural stream
        if (redirect_valid) begin
`ifdef MISALIGN_TRAP_EN
          tgt = redirect_pc;
          if (tgt[1:0] != 2'b00) begin
            faulted     = 1'b1;
            p_req_stall = 1'b0;
            p_id_hold   = 1'b0;
          end
`else
          tgt = {redirect_pc[31:2], 2'b00};
`endif
          if (imem_req_valid && !imem_req_ready) req_stale = 1'b1;
          exp_q.delete();
          exp_fetch = tgt;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [15:0] rdy_pat  = 16'b1101_1111_0111_1011;
  logic [15:0] idr_pat  = 16'b1011_0110_1110_0111;
  logic [63:0] redir_mk = 64'h0080_0700_0200_0C00;
  int          lat_tab[5] = '{1, 2, 1, 4, 3};

  initial begin
    logic [31:0] a;
    logic [31:0] pc0;
    logic [31:0] inst0;
    bit          ev;
    bit          iv;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'd0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_inst", id_inst, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_misaligned", {31'b0, fetch_misaligned}, 32'd0);

    // T1: k=1, id_ready=1 -> requests at cycles 1,4,7
    to_drive();
    rst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      ev = (c == 1) || (c == 4) || (c == 7);
      iv = (c == 3) || (c == 6);
      chk("t1_req_valid", {31'b0, imem_req_valid}, {31'b0, ev});
      if (ev) chk("t1_req_addr", imem_req_addr, RST_PC + 32'(4 * ((c - 1) / 3)));
      chk("t1_id_valid", {31'b0, id_valid}, {31'b0, iv});
      if (iv) begin
        chk("t1_id_pc", id_pc, RST_PC + 32'(4 * ((c - 3) / 3)));
        chk("t1_id_inst", id_inst, mem_word(RST_PC + 32'(4 * ((c - 3) / 3))));
      end
    end

    // T2: decode stalls 5 cycles in HOLD
    to_drive();
    id_ready = 1'b0;
    wait_id("t2_wait_hold");
    pc0   = id_pc;
    inst0 = id_inst;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t2_hold_valid", {31'b0, id_valid}, 32'd1);
      chk("t2_hold_pc", id_pc, pc0);
      chk("t2_hold_inst", id_inst, inst0);
      chk("t2_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    to_drive();
    id_ready = 1'b1;
    @(negedge clk);
    chk("t2_handshake_valid", {31'b0, id_valid}, 32'd1);
    @(negedge clk);
    chk("t2_next_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t2_next_req_addr", imem_req_addr, pc0 + 32'd4);

    // T3: redirect to 0x2000 in WAIT with k=3
    to_drive();
    lat = 3;
    wait_accept("t3_accept", a);
    for (int k = 1; k <= 4; k++) begin
      to_drive();
      if (k == 1) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
      end
      if (k == 2) redirect_valid = 1'b0;
      @(negedge clk);
      chk("t3_id_quiet", {31'b0, id_valid}, 32'd0);
      chk("t3_req_valid", {31'b0, imem_req_valid}, {31'b0, (k == 4)});
      if (k == 4) chk("t3_req_addr", imem_req_addr, 32'h0000_2000);
    end
    wait_id("t3_wait_id");
    chk("t3_first_id_pc", id_pc, 32'h0000_2000);

    // T4: request stalled 3 cycles, redirect to 0x3000 mid-stall
    to_drive();
    lat = 1;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i <= 3) begin
        chk("t4_stall_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t4_stall_addr", imem_req_addr, 32'h0000_2004);
      end else if (i == 4) begin
        chk("t4_drain_noreq", {31'b0, imem_req_valid}, 32'd0);
      end else begin
        chk("t4_new_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t4_new_addr", imem_req_addr, 32'h0000_3000);
      end
      to_drive();
      if (i == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
      end
      if (i == 1) redirect_valid = 1'b0;
      if (i == 2) imem_req_ready = 1'b1;
    end
    wait_id("t4_wait_id");
    chk("t4_first_id_pc", id_pc, 32'h0000_3000);

    // T5: sequential fetch wraps from 0xFFFF_FFFC to 0
    to_drive();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    to_drive();
    redirect_valid = 1'b0;
    a = 32'h0;
    for (int t = 0; t < 4 && a != 32'hFFFF_FFFC; t++) wait_accept("t5_accept", a);
    chk("t5_wrap_seen", a, 32'hFFFF_FFFC);
    wait_accept("t5_accept_next", a);
    chk("t5_wrap_next", a, 32'h0000_0000);

    // T6: misaligned redirect target 0x2002 from HOLD
    to_drive();
    id_ready = 1'b0;
    wait_id("t6_wait_hold");
    to_drive();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2002;
    @(negedge clk);
    to_drive();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    @(negedge clk);
`ifdef MISALIGN_TRAP_EN
    chk("t6_misaligned", {31'b0, fetch_misaligned}, 32'd1);
    chk("t6_no_req", {31'b0, imem_req_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_fault_quiet", {31'b0, imem_req_valid}, 32'd0);
    end
`else
    chk("t6_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t6_req_addr", imem_req_addr, 32'h0000_2000);
    chk("t6_misaligned", {31'b0, fetch_misaligned}, 32'd0);
    wait_id("t6_wait_id");
    chk("t6_id_pc", id_pc, 32'h0000_2000);
`endif

    // T7: asynchronous reset mid-transaction
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t7_rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("t7_rst_id_pc", id_pc, 32'd0);
    chk("t7_rst_id_inst", id_inst, 32'd0);
    chk("t7_rst_misaligned", {31'b0, fetch_misaligned}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t7_boot_noreq", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    chk("t7_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t7_first_req_addr", imem_req_addr, RST_PC);

    // T8: mixed stalls, latencies and redirects (model-checked)
    for (int i = 0; i < 64; i++) begin
      to_drive();
      imem_req_ready = rdy_pat[i % 16];
      id_ready       = idr_pat[(i * 3) % 16];
      lat            = lat_tab[i % 5];
      redirect_valid = redir_mk[i];
      redirect_pc    = 32'h0000_4000 + 32'(i * 16);
    end
    to_drive();
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    lat            = 1;
    wait_id("t8_live_1");
    to_drive();
    wait_id("t8_live_2");
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
